oam_dma: RTL and testbench

//  CPU-side OAM DMA engine (NES $4014). A write of page P to $4014 halts the CPU,

---
 rtl/oam_dma.sv | 91 +++++++++
 tb/tb_oam_dma.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/oam_dma.sv
// Sprite DMA engine behind the $4014 register. It halts the CPU and copies page P
// into sprite OAM, one byte per read/write pair, through the oam_load/data_in path.
module oam_dma #(
    parameter int BYTES    = 256,
    parameter bit ALIGN_EN = 1'b1
) (
    input  logic        clk,
    input  logic        i_rst_n,
    input  logic        ce,
    input  logic        i_reg_wr,
    input  logic [7:0]  i_reg_data,
    output logic        o_halt,
    output logic        o_busy,
    output logic        o_mem_rd,
    output logic [15:0] o_mem_addr,
    input  logic [7:0]  i_mem_data,
    output logic        o_oam_load,
    output logic [7:0]  o_oam_data,
    output logic        o_done
);

    // state | meaning
    // IDLE  | waiting for a $4014 write
    // HALT  | CPU halted, no bus activity for one cycle
    // ALIGN | extra idle cycle so the first read lands on a get cycle
    // READ  | get cycle: read {page,cnt} and capture the byte
    // WRITE | put cycle: push the captured byte to OAM, advance cnt
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_HALT  = 3'd1;
    localparam logic [2:0] S_ALIGN = 3'd2;
    localparam logic [2:0] S_READ  = 3'd3;
    localparam logic [2:0] S_WRITE = 3'd4;

    localparam logic [7:0] LAST_CNT = 8'(BYTES - 1);

    logic [2:0] state;
    logic [7:0] cnt;
    logic [7:0] page;
    logic [7:0] latch;
    logic       phase;
    logic       done_q;

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state  <= S_IDLE;
            cnt    <= 8'd0;
            page   <= 8'd0;
            latch  <= 8'd0;
            phase  <= 1'b0;
            done_q <= 1'b0;
        end else if (ce) begin
            phase  <= ~phase;
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_reg_wr) begin
                        page  <= i_reg_data;
                        cnt   <= 8'd0;
                        state <= S_HALT;
                    end
                end
                // phase=1 now means the next cycle is a get cycle
                S_HALT:  state <= (phase || !ALIGN_EN) ? S_READ : S_ALIGN;
                S_ALIGN: state <= S_READ;
                S_READ: begin
                    latch <= i_mem_data;
                    state <= S_WRITE;
                end
                S_WRITE: begin
                    cnt <= cnt + 8'd1;
                    if (cnt == LAST_CNT) begin
                        state  <= S_IDLE;
                        done_q <= 1'b1;
                    end else begin
                        state <= S_READ;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign o_halt     = (state != S_IDLE);
    assign o_busy     = (state != S_IDLE);
    assign o_mem_rd   = (state == S_READ);
    assign o_mem_addr = (state == S_READ) ? {page, cnt} : 16'h0000;
    assign o_oam_load = (state == S_WRITE);
    assign o_oam_data = latch;
    assign o_done     = done_q;

endmodule

// File: tb/tb_oam_dma.sv
// Bench for oam_dma: randomized pages, memory keys and ce patterns against a
// transfer-level model (address list, byte list, halt length, done count).
module tb_oam_dma;
    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic        ce       = 1'b0;
    logic        reg_wr   = 1'b0;
    logic [7:0]  reg_data = 8'h00;
    logic [7:0]  key      = 8'h00;
    logic        halt, busy, mem_rd, oam_load, done;
    logic [15:0] mem_addr;
    logic [7:0]  mem_data, oam_data;

    int n_tests = 0;
    int n_fail  = 0;

    oam_dma dut (
        .clk        (clk),
        .i_rst_n    (rst_n),
        .ce         (ce),
        .i_reg_wr   (reg_wr),
        .i_reg_data (reg_data),
        .o_halt     (halt),
        .o_busy     (busy),
        .o_mem_rd   (mem_rd),
        .o_mem_addr (mem_addr),
        .i_mem_data (mem_data),
        .o_oam_load (oam_load),
        .o_oam_data (oam_data),
        .o_done     (done)
    );

    always #5 clk = ~clk;

    assign mem_data = mem_addr[7:0] ^ key;

    // bus monitor, sampled mid-cycle
    logic [15:0] rd_q[$];
    logic [7:0]  ld_q[$];
    int ce_seen = 0, halt_ce = 0, halt_raw = 0, done_cnt = 0;
    int adj_err = 0, idle_addr_err = 0, busy_err = 0, freeze_err = 0;
    int ld_last_idx = 0, done_idx = 0;
    logic prev_rd = 1'b0, prev_ce = 1'b0, prev_rst = 1'b0;
    logic [28:0] snap = '0;
    logic [28:0] cur;
    assign cur = {halt, busy, mem_rd, mem_addr, oam_load, oam_data, done};

    always @(negedge clk) begin
        if (!rst_n) begin
            ce_seen <= 0;
            prev_rd <= 1'b0;
        end else begin
            if (busy !== halt) busy_err <= busy_err + 1;
            if (!mem_rd && mem_addr !== 16'h0000) idle_addr_err <= idle_addr_err + 1;
            if (prev_rst && !prev_ce && cur !== snap) freeze_err <= freeze_err + 1;
            if (halt) halt_raw <= halt_raw + 1;
            if (ce) begin
                if (halt) halt_ce <= halt_ce + 1;
                if (mem_rd) rd_q.push_back(mem_addr);
                if (oam_load) begin
                    if (!prev_rd) adj_err <= adj_err + 1;
                    ld_q.push_back(oam_data);
                    ld_last_idx <= ce_seen;
                end
                if (done) begin
                    done_cnt <= done_cnt + 1;
                    done_idx <= ce_seen;
                end
                prev_rd <= mem_rd;
                ce_seen <= ce_seen + 1;
            end
        end
        prev_ce  <= ce;
        prev_rst <= rst_n;
        snap     <= cur;
    end

    // transfer-level model and per-test baselines
    logic [15:0] exp_rd[$];
    logic [7:0]  exp_ld[$];
    int exp_halt;
    int b_rd, b_ld, b_halt_ce, b_halt_raw, b_done, b_adj, b_idle, b_busy, b_freeze;
    bit timed_out;

    task automatic model_xfer(input logic [7:0] p);
        for (int i = 0; i < 256; i++) begin
            exp_rd.push_back({p, 8'(i)});
            exp_ld.push_back(8'(i) ^ key);
        end
    endtask

    task automatic mark();
        b_rd = rd_q.size();   b_ld = ld_q.size();
        b_halt_ce = halt_ce;  b_halt_raw = halt_raw;
        b_done = done_cnt;    b_adj = adj_err;
        b_idle = idle_addr_err; b_busy = busy_err; b_freeze = freeze_err;
        exp_rd.delete(); exp_ld.delete(); exp_halt = 0;
    endtask

    task automatic tick(input logic c, input logic w, input logic [7:0] d);
        ce = c; reg_wr = w; reg_data = d;
        @(posedge clk); #1;
    endtask

    function automatic logic ce_at(input int period, input int k);
        if (period == 0) return 1'($urandom_range(0, 1));
        return (k % period) == 0;
    endfunction

    task automatic align_phase(input int want);
        if ((ce_seen % 2) != want) tick(1'b1, 1'b0, 8'h00);
    endtask

    task automatic run_xfer(input logic [7:0] page, input int period, input bit mid_wr,
                            input bit chain, input logic [7:0] page2);
        int k, budget, target;
        bit mid_done, chained;
        logic c, w;
        logic [7:0] d;
        k = 1; mid_done = 0; chained = 0;
        target = chain ? 2 : 1;
        budget = 700 * ((period == 0) ? 4 : period) * target + 50;
        exp_halt += (ce_seen % 2 == 0) ? 513 : 514;
        model_xfer(page);
        tick(1'b1, 1'b1, page);
        while ((done_cnt - b_done) < target && k < budget) begin
            c = ce_at(period, k); w = 1'b0; d = 8'h00;
            if (chain && !chained && done) begin
                c = 1'b1; w = 1'b1; d = page2; chained = 1;
                exp_halt += (ce_seen % 2 == 0) ? 513 : 514;
                model_xfer(page2);
            end else if (mid_wr && !mid_done && (ld_q.size() - b_ld) == 100) begin
                c = 1'b1; w = 1'b1; d = 8'h07; mid_done = 1;
            end
            tick(c, w, d);
            k++;
        end
        timed_out = (k >= budget);
        repeat (6) tick(1'b1, 1'b0, 8'h00);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (cur !== 29'h0) begin
            n_fail++; $display("FAIL reset_outputs: got %h required 0", cur);
        end
        rst_n = 1'b1;
        tick(1'b0, 1'b0, 8'h00);
        tick(1'b0, 1'b1, 8'h55);
        repeat (2) tick(1'b0, 1'b0, 8'h00);
        n_tests++;
        if (cur !== 29'h0) begin
            n_fail++; $display("FAIL reset_wr_without_ce: got %h required 0", cur);
        end
    endtask

    task automatic test_aligned();
        key = 8'($urandom);
        align_phase(0);
        mark();
        run_xfer(8'h02, 1, 0, 0, 8'h00);
        n_tests++;
        if (timed_out || rd_q.size() - b_rd != 256 || ld_q.size() - b_ld != 256) begin
            n_fail++; $display("FAIL aligned_count: timeout=%0b reads=%0d loads=%0d required 256/256",
                               timed_out, rd_q.size() - b_rd, ld_q.size() - b_ld);
        end
        for (int i = 0; i < exp_rd.size() && i < rd_q.size() - b_rd; i++) begin
            n_tests++;
            if (rd_q[b_rd+i] !== exp_rd[i]) begin
                n_fail++; $display("FAIL aligned_addr[%0d]: got %h required %h", i, rd_q[b_rd+i], exp_rd[i]);
                break;
            end
        end
        for (int i = 0; i < exp_ld.size() && i < ld_q.size() - b_ld; i++) begin
            n_tests++;
            if (ld_q[b_ld+i] !== exp_ld[i]) begin
                n_fail++; $display("FAIL aligned_data[%0d]: got %h required %h", i, ld_q[b_ld+i], exp_ld[i]);
                break;
            end
        end
        n_tests++;
        if (halt_ce - b_halt_ce !== exp_halt) begin
            n_fail++; $display("FAIL aligned_halt_len: got %0d required %0d", halt_ce - b_halt_ce, exp_halt);
        end
        n_tests++;
        if (done_cnt - b_done !== 1 || done_idx !== ld_last_idx + 1) begin
            n_fail++; $display("FAIL aligned_done: pulses %0d at %0d, last load %0d; required 1 pulse right after",
                               done_cnt - b_done, done_idx, ld_last_idx);
        end
        n_tests++;
        if ((adj_err - b_adj) + (idle_addr_err - b_idle) + (busy_err - b_busy) != 0) begin
            n_fail++; $display("FAIL aligned_rules: adj=%0d idle_addr=%0d busy=%0d required 0",
                               adj_err - b_adj, idle_addr_err - b_idle, busy_err - b_busy);
        end
    endtask

    task automatic test_align_cycle();
        logic [7:0] p;
        p = 8'($urandom);
        key = 8'($urandom);
        align_phase(1);
        mark();
        run_xfer(p, 1, 0, 0, 8'h00);
        n_tests++;
        if (exp_halt != 514 || halt_ce - b_halt_ce !== 514) begin
            n_fail++; $display("FAIL align_halt_len: got %0d required 514 (model %0d)", halt_ce - b_halt_ce, exp_halt);
        end
        n_tests++;
        if (timed_out || rd_q.size() - b_rd != 256 || ld_q.size() - b_ld != 256) begin
            n_fail++; $display("FAIL align_count: timeout=%0b reads=%0d loads=%0d required 256/256",
                               timed_out, rd_q.size() - b_rd, ld_q.size() - b_ld);
        end
        for (int i = 0; i < exp_rd.size() && i < rd_q.size() - b_rd; i++) begin
            n_tests++;
            if (rd_q[b_rd+i] !== exp_rd[i]) begin
                n_fail++; $display("FAIL align_addr[%0d]: got %h required %h", i, rd_q[b_rd+i], exp_rd[i]);
                break;
            end
        end
        n_tests++;
        if (done_cnt - b_done !== 1 || (adj_err - b_adj) + (idle_addr_err - b_idle) != 0) begin
            n_fail++; $display("FAIL align_done_rules: done=%0d adj=%0d idle_addr=%0d required 1/0/0",
                               done_cnt - b_done, adj_err - b_adj, idle_addr_err - b_idle);
        end
    endtask

    task automatic test_xor_data();
        logic [7:0] p;
        p = 8'($urandom);
        key = 8'hA5;
        mark();
        run_xfer(p, 1, 0, 0, 8'h00);
        n_tests++;
        if (timed_out || ld_q.size() - b_ld != 256) begin
            n_fail++; $display("FAIL xor_count: timeout=%0b loads=%0d required 256", timed_out, ld_q.size() - b_ld);
        end
        for (int i = 0; i < exp_ld.size() && i < ld_q.size() - b_ld; i++) begin
            n_tests++;
            if (ld_q[b_ld+i] !== exp_ld[i]) begin
                n_fail++; $display("FAIL xor_data[%0d]: got %h required %h", i, ld_q[b_ld+i], exp_ld[i]);
                break;
            end
        end
        n_tests++;
        if (ld_q.size() - b_ld == 256 && (ld_q[b_ld] !== 8'hA5 || ld_q[b_ld+255] !== 8'h5A)) begin
            n_fail++; $display("FAIL xor_ends: got %h..%h required a5..5a", ld_q[b_ld], ld_q[b_ld+255]);
        end
        n_tests++;
        if (adj_err - b_adj != 0) begin
            n_fail++; $display("FAIL xor_adjacent: %0d loads not one cycle after a read, required 0", adj_err - b_adj);
        end
    endtask

    task automatic test_ce_stretch();
        logic [7:0] p;
        for (int pass = 0; pass < 2; pass++) begin
            p = 8'($urandom);
            key = 8'($urandom);
            mark();
            run_xfer(p, (pass == 0) ? 3 : 0, 0, 0, 8'h00);
            n_tests++;
            if (timed_out || rd_q.size() - b_rd != 256 || ld_q.size() - b_ld != 256) begin
                n_fail++; $display("FAIL ce%0d_count: timeout=%0b reads=%0d loads=%0d required 256/256",
                                   pass, timed_out, rd_q.size() - b_rd, ld_q.size() - b_ld);
            end
            for (int i = 0; i < exp_rd.size() && i < rd_q.size() - b_rd && i < ld_q.size() - b_ld; i++) begin
                n_tests++;
                if (rd_q[b_rd+i] !== exp_rd[i] || ld_q[b_ld+i] !== exp_ld[i]) begin
                    n_fail++; $display("FAIL ce%0d_xfer[%0d]: got %h/%h required %h/%h", pass, i,
                                       rd_q[b_rd+i], ld_q[b_ld+i], exp_rd[i], exp_ld[i]);
                    break;
                end
            end
            n_tests++;
            if (halt_ce - b_halt_ce !== exp_halt || done_cnt - b_done !== 1) begin
                n_fail++; $display("FAIL ce%0d_halt_done: halt %0d done %0d required %0d/1",
                                   pass, halt_ce - b_halt_ce, done_cnt - b_done, exp_halt);
            end
            if (pass == 0) begin
                n_tests++;
                if (halt_raw - b_halt_raw !== exp_halt * 3) begin
                    n_fail++; $display("FAIL ce_stretch_raw: got %0d cycles required %0d", halt_raw - b_halt_raw, exp_halt * 3);
                end
            end
            n_tests++;
            if (freeze_err - b_freeze != 0 || adj_err - b_adj != 0) begin
                n_fail++; $display("FAIL ce%0d_freeze: changes while ce=0 %0d, adj %0d required 0/0",
                                   pass, freeze_err - b_freeze, adj_err - b_adj);
            end
        end
    endtask

    task automatic test_back_to_back();
        key = 8'($urandom);
        mark();
        run_xfer(8'h02, 1, 1, 1, 8'h07);
        n_tests++;
        if (timed_out || rd_q.size() - b_rd != 512 || ld_q.size() - b_ld != 512) begin
            n_fail++; $display("FAIL b2b_count: timeout=%0b reads=%0d loads=%0d required 512/512",
                               timed_out, rd_q.size() - b_rd, ld_q.size() - b_ld);
        end
        for (int i = 0; i < exp_rd.size() && i < rd_q.size() - b_rd; i++) begin
            n_tests++;
            if (rd_q[b_rd+i] !== exp_rd[i]) begin
                n_fail++; $display("FAIL b2b_addr[%0d]: got %h required %h", i, rd_q[b_rd+i], exp_rd[i]);
                break;
            end
        end
        n_tests++;
        if (halt_ce - b_halt_ce !== exp_halt) begin
            n_fail++; $display("FAIL b2b_halt_len: got %0d required %0d", halt_ce - b_halt_ce, exp_halt);
        end
        n_tests++;
        if (done_cnt - b_done !== 2 || done_idx !== ld_last_idx + 1) begin
            n_fail++; $display("FAIL b2b_done: pulses %0d required 2 (last at %0d, last load %0d)",
                               done_cnt - b_done, done_idx, ld_last_idx);
        end
    endtask

    task automatic test_reset_abort();
        int k;
        logic [7:0] p;
        key = 8'($urandom);
        mark();
        tick(1'b1, 1'b1, 8'h02);
        k = 0;
        while ((ld_q.size() - b_ld) < 40 && k < 200) begin
            tick(1'b1, 1'b0, 8'h00);
            k++;
        end
        n_tests++;
        if (k >= 200) begin
            n_fail++; $display("FAIL abort_reach: loads %0d required 40 within budget", ld_q.size() - b_ld);
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({halt, busy, mem_rd, oam_load, done} !== 5'b0) begin
            n_fail++; $display("FAIL abort_async: halt/busy/rd/load/done=%b required 00000",
                               {halt, busy, mem_rd, oam_load, done});
        end
        tick(1'b1, 1'b0, 8'h00);
        tick(1'b1, 1'b1, 8'h33);
        rst_n = 1'b1;
        repeat (5) tick(1'b1, 1'b0, 8'h00);
        n_tests++;
        if (done_cnt - b_done !== 0 || halt !== 1'b0 || oam_data !== 8'h00) begin
            n_fail++; $display("FAIL abort_quiet: done %0d halt %b data %h required 0/0/00",
                               done_cnt - b_done, halt, oam_data);
        end
        p = 8'($urandom);
        mark();
        run_xfer(p, 1, 0, 0, 8'h00);
        n_tests++;
        if (timed_out || rd_q.size() - b_rd != 256 || done_cnt - b_done != 1) begin
            n_fail++; $display("FAIL abort_restart_count: timeout=%0b reads=%0d done=%0d required 256/1",
                               timed_out, rd_q.size() - b_rd, done_cnt - b_done);
        end
        for (int i = 0; i < exp_rd.size() && i < rd_q.size() - b_rd; i++) begin
            n_tests++;
            if (rd_q[b_rd+i] !== exp_rd[i]) begin
                n_fail++; $display("FAIL abort_restart_addr[%0d]: got %h required %h", i, rd_q[b_rd+i], exp_rd[i]);
                break;
            end
        end
        n_tests++;
        if (halt_ce - b_halt_ce !== exp_halt) begin
            n_fail++; $display("FAIL abort_restart_halt: got %0d required %0d", halt_ce - b_halt_ce, exp_halt);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_aligned();
        test_align_cycle();
        test_xor_data();
        test_ce_stretch();
        test_back_to_back();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
